// File: rtl/shift_ser_pkg.sv
// rtl/shift_ser_pkg.sv - shared state type, default sizes and counter width helper for shift_ser_out
package shift_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int SER_WIDTH  = 8;
    localparam int SER_CLKDIV = 2;

    // A divide-by-one counter still needs one bit to hold its single state.
    function automatic int div_cnt_w(input int clkdiv);
        return (clkdiv <= 1) ? 1 : $clog2(clkdiv);
    endfunction

endpackage

// File: rtl/shift_ser_out_if.sv
// rtl/shift_ser_out_if.sv - valid/ready word handshake between the data source and shift_ser_out
interface shift_ser_out_if
    import shift_ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ser_clk_div.sv
// rtl/ser_clk_div.sv - half-period tick generator for the serial clock, with synchronous restart
module ser_clk_div
    import shift_ser_pkg::*;
#(
    parameter int CLKDIV = SER_CLKDIV
) (
    input  logic serclk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = div_cnt_w(CLKDIV);
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge serclk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the CLKDIV-th edge after a restart, then every CLKDIV edges.
    assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/shift_ser_out.sv
// rtl/shift_ser_out.sv - MSB-first serial transmitter with sclk/latch generation; SHIFT_SER_OUT_BUF_EN adds a one-word holding buffer
module shift_ser_out
    import shift_ser_pkg::*;
#(
    parameter int WIDTH  = SER_WIDTH,
    parameter int CLKDIV = SER_CLKDIV
) (
    input  logic            serclk,
    input  logic            reset,
    shift_ser_out_if.slave  in_if,
    output logic            sdo,
    output logic            sclk_o,
    output logic            latch_o,
    output logic            busy
);
    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] next_word;
    logic             tick;
    logic             xfer;

`ifdef SHIFT_SER_OUT_BUF_EN
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;

    assign in_if.in_ready = reset && !buf_full;
    assign next_word      = buf_full ? buf_data : in_if.in_data;
`else
    assign in_if.in_ready = reset && (state == IDLE);
    assign next_word      = in_if.in_data;
`endif

    assign xfer = in_if.in_valid && in_if.in_ready;

    ser_clk_div #(.CLKDIV(CLKDIV)) u_clk_div (
        .serclk  (serclk),
        .reset   (reset),
        .restart (state == IDLE),
        .tick    (tick)
    );

    // shreg holds the bits still to be sent, next one at the MSB; sdo already carries the current bit.
    always_ff @(posedge serclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            sdo     <= 1'b0;
            sclk_o  <= 1'b0;
            latch_o <= 1'b0;
            busy    <= 1'b0;
`ifdef SHIFT_SER_OUT_BUF_EN
            buf_full <= 1'b0;
            buf_data <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg  <= {next_word[WIDTH-2:0], 1'b0};
                        bitcnt <= LAST_BIT;
                        sdo    <= next_word[WIDTH-1];
                        sclk_o <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sclk_o) begin
                            sclk_o <= 1'b0;
                        end else if (bitcnt != '0) begin
                            sdo    <= shreg[WIDTH-1];
                            shreg  <= {shreg[WIDTH-2:0], 1'b0};
                            sclk_o <= 1'b1;
                            bitcnt <= bitcnt - 1'b1;
                        end else begin
                            sdo     <= 1'b0;
                            latch_o <= 1'b1;
                            state   <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        latch_o <= 1'b0;
`ifdef SHIFT_SER_OUT_BUF_EN
                        if (buf_full || xfer) begin
                            shreg    <= {next_word[WIDTH-2:0], 1'b0};
                            bitcnt   <= LAST_BIT;
                            sdo      <= next_word[WIDTH-1];
                            sclk_o   <= 1'b1;
                            buf_full <= 1'b0;
                            state    <= SHIFT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
`ifdef SHIFT_SER_OUT_BUF_EN
            // A word arriving on the final LATCH edge goes straight to shreg instead.
            if (xfer && state != IDLE && !(state == LATCH && tick)) begin
                buf_data <= in_if.in_data;
                buf_full <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shift_ser_out.sv
// tb/tb_shift_ser_out.sv - scoreboard bench for shift_ser_out with a behavioural shift-left receiver
module tb_shift_ser_out;
    import shift_ser_pkg::*;

    logic serclk = 1'b0;
    logic reset  = 1'b0;
    always #5 serclk = ~serclk;

    shift_ser_out_if #(.WIDTH(8)) bus8 ();
    shift_ser_out_if #(.WIDTH(4)) bus4 ();
    logic sdo8, sclk8, lat8, busy8;
    logic sdo4, sclk4, lat4, busy4;

    shift_ser_out #(.WIDTH(8), .CLKDIV(2)) dut (
        .serclk(serclk), .reset(reset), .in_if(bus8),
        .sdo(sdo8), .sclk_o(sclk8), .latch_o(lat8), .busy(busy8)
    );
    shift_ser_out #(.WIDTH(4), .CLKDIV(1)) dut4 (
        .serclk(serclk), .reset(reset), .in_if(bus4),
        .sdo(sdo4), .sclk_o(sclk4), .latch_o(lat4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;
    always @(posedge serclk) cyc <= cyc + 1;

    logic [7:0] exp8[$];
    logic [3:0] exp4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Receiver model: shift sdo in on every sclk falling edge, capture at the rising edge of latch.
    logic       p_sclk8 = 1'b0, p_lat8 = 1'b0;
    logic [7:0] rx8 = '0;
    int         rxn8 = 0, latn8 = 0;
    always @(negedge serclk) begin
        if (!reset) begin
            rx8 = '0; rxn8 = 0; latn8 = 0;
        end else begin
            if (p_sclk8 && !sclk8) begin rx8 = {rx8[6:0], sdo8}; rxn8++; end
            if (lat8 && !p_lat8) begin
                chk("queue8_nonempty", exp8.size() > 0, 1'b1);
                if (exp8.size() > 0) chk("word8", rx8, exp8.pop_front());
                chk("falls8", rxn8, 8);
                rxn8 = 0;
            end
            if (lat8) latn8++;
            else if (p_lat8) begin chk("latch8_len", latn8, 2); latn8 = 0; end
            chk("sclk8_quiet", sclk8 && (!busy8 || lat8), 1'b0);
        end
        p_sclk8 = sclk8; p_lat8 = lat8;
    end

    logic       p_sclk4 = 1'b0, p_lat4 = 1'b0;
    logic [3:0] rx4 = '0;
    int         rxn4 = 0, latn4 = 0;
    always @(negedge serclk) begin
        if (!reset) begin
            rx4 = '0; rxn4 = 0; latn4 = 0;
        end else begin
            if (p_sclk4 && !sclk4) begin rx4 = {rx4[2:0], sdo4}; rxn4++; end
            if (lat4 && !p_lat4) begin
                chk("queue4_nonempty", exp4.size() > 0, 1'b1);
                if (exp4.size() > 0) chk("word4", rx4, exp4.pop_front());
                chk("falls4", rxn4, 4);
                rxn4 = 0;
            end
            if (lat4) latn4++;
            else if (p_lat4) begin chk("latch4_len", latn4, 1); latn4 = 0; end
            chk("sclk4_quiet", sclk4 && (!busy4 || lat4), 1'b0);
        end
        p_sclk4 = sclk4; p_lat4 = lat4;
    end

    task automatic send8(input logic [7:0] w, input bit hold, output int unsigned hs);
        int t = 0;
        @(negedge serclk);
        bus8.in_data = w; bus8.in_valid = 1'b1;
        #1;
        while (!bus8.in_ready && t < 300) begin @(negedge serclk); #1; t++; end
        chk("hs8_wait", t < 300, 1'b1);
        @(posedge serclk); #1;
        hs = cyc;
        exp8.push_back(w);
        if (!hold) bus8.in_valid = 1'b0;
    endtask

    task automatic wait_idle8(input string name);
        int t = 0;
        @(negedge serclk);
        while (busy8 && t < 300) begin @(negedge serclk); t++; end
        chk(name, t < 300, 1'b1);
    endtask

    initial begin
        int unsigned c1, c2;
        int n;
        logic [7:0] w;
        bus8.in_valid = 1'b0; bus8.in_data = '0;
        bus4.in_valid = 1'b0; bus4.in_data = '0;

        repeat (2) @(negedge serclk);
        #1;
        chk("rst_sdo", sdo8, 0); chk("rst_sclk", sclk8, 0); chk("rst_latch", lat8, 0);
        chk("rst_busy", busy8, 0); chk("rst_ready", bus8.in_ready, 0);
        reset = 1'b1;
        @(negedge serclk); #1;
        chk("ready_after_rst", bus8.in_ready, 1);

        for (int i = 0; i < 20; i++) begin
            @(negedge serclk); #1;
            chk("idle_sclk", sclk8, 0); chk("idle_latch", lat8, 0);
            chk("idle_busy", busy8, 0); chk("idle_ready", bus8.in_ready, 1);
        end

        send8(8'hA5, 1'b0, c1);
        n = 0;
        @(negedge serclk);
        while (busy8 && n < 300) begin n++; @(negedge serclk); end
        chk("a5_busy_cycles", n, 34);

        send8(8'h00, 1'b1, c1);
        send8(8'hFF, 1'b0, c2);
`ifdef SHIFT_SER_OUT_BUF_EN
        chk("b2b_buffered_hs", c2 - c1, 1);
        n = 0;
        @(negedge serclk);
        while (!lat8 && n < 300) begin @(negedge serclk); n++; end
        while (lat8 && n < 300) begin @(negedge serclk); n++; end
        chk("b2b_no_gap_sclk", sclk8, 1);
        chk("b2b_no_gap_busy", busy8, 1);
`else
        chk("b2b_hs_gap", c2 - c1, 35);
`endif
        wait_idle8("b2b_done");

        send8(8'h81, 1'b0, c1);
        repeat (2) @(negedge serclk);
        bus8.in_data = 8'h3C;
        wait_idle8("hold_data_done");

        send8(8'hF0, 1'b0, c1);
        n = 0;
        while (rxn8 < 4 && n < 300) begin @(negedge serclk); #1; n++; end
        chk("abort_reached_bit4", rxn8, 4);
        chk("abort_busy_before", busy8, 1);
        reset = 1'b0;
        #1;
        chk("abort_sclk", sclk8, 0); chk("abort_sdo", sdo8, 0);
        chk("abort_latch", lat8, 0); chk("abort_busy", busy8, 0);
        chk("abort_ready", bus8.in_ready, 0);
        void'(exp8.pop_back());
        repeat (3) begin @(negedge serclk); chk("abort_no_latch", lat8, 0); end
        reset = 1'b1;
        repeat (3) begin @(negedge serclk); chk("post_abort_no_latch", lat8, 0); end
        send8(8'h5A, 1'b0, c1);
        wait_idle8("post_abort_done");

        @(negedge serclk);
        bus4.in_data = 4'h9; bus4.in_valid = 1'b1;
        #1;
        chk("ready4", bus4.in_ready, 1);
        @(posedge serclk); #1;
        exp4.push_back(4'h9);
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge serclk);
            chk("div1_sclk", sclk4, (i < 8) && (i % 2 == 0));
            chk("div1_latch", lat4, i == 8);
            chk("div1_busy", busy4, 1);
        end
        @(negedge serclk);
        chk("div1_total", busy4, 0);

        for (int i = 0; i < 20; i++) begin
            int gap;
            w = 8'($urandom);
            gap = (i == 19) ? 1 : int'($urandom_range(0, 5));
            send8(w, gap == 0, c1);
            repeat (gap) @(negedge serclk);
        end
        bus8.in_valid = 1'b0;
        wait_idle8("rand_done");
        repeat (4) @(negedge serclk);
        chk("exp8_drained", exp8.size(), 0);
        chk("exp4_drained", exp4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
